// File: rtl/sale_terminal_pkg.sv
// Shared constants, price table, FSM encoding and op codes for the sale terminal basket.
package sale_terminal_pkg;

    localparam int NUM_PRODUCTS = 12;
    localparam int QTY_W        = 4;
    localparam int PRICE_W      = 8;
    localparam int TOTAL_W      = 16;
    localparam int ID_W         = 4;
    localparam int COUNT_W      = 8;
    localparam int PROD_W       = PRICE_W + QTY_W;

    localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(NUM_PRODUCTS);

    // Unit price of product i is 5*(i+1)
    localparam logic [PRICE_W-1:0] PRICE_TABLE [NUM_PRODUCTS] = '{
        8'd5,  8'd10, 8'd15, 8'd20, 8'd25, 8'd30,
        8'd35, 8'd40, 8'd45, 8'd50, 8'd55, 8'd60
    };

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_REMOVE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        UPDATE,
        DONE,
        ERRS
    } state_t;

endpackage

// File: rtl/product_price_rom.sv
// Constant price lookup: product ID to unit price, zero for IDs with no slot.
module product_price_rom
    import sale_terminal_pkg::*;
(
    input  logic [ID_W-1:0]    id,
    output logic [PRICE_W-1:0] price
);

    // Walk the table so an out-of-range ID simply never matches and prices at zero
    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (id == ID_W'(i)) begin
                price = PRICE_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/basket_controller.sv
// Basket command consumer: validates add/remove commands, multiplies unit price by
// quantity with a 4-cycle shift-add, and keeps per-product quantities and totals.
module basket_controller
    import sale_terminal_pkg::*;
(
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic                    CMD_EN,
    input  logic                    CMD_OP,
    input  logic [ID_W-1:0]         PRODUCT_ID,
    input  logic [QTY_W-1:0]        PRODUCT_QTY,
    input  logic                    CLEAR,
    input  logic [ID_W-1:0]         RD_ID,
    output logic [QTY_W-1:0]        RD_QTY,
    output logic [NUM_PRODUCTS-1:0] LINE_NONEMPTY,
    output logic [COUNT_W-1:0]      ITEM_COUNT,
    output logic [TOTAL_W-1:0]      TOTAL_PRICE,
    output logic                    BUSY,
    output logic                    ACK,
    output logic                    ERR
);

    state_t             state;
    logic               op_r;
    logic [ID_W-1:0]    id_r;
    logic [QTY_W-1:0]   qty_r;
    logic [QTY_W-1:0]   qty_mem [NUM_PRODUCTS];

    logic [PROD_W-1:0]  mcand;
    logic [QTY_W-1:0]   mplier;
    logic [PROD_W-1:0]  product;
    logic [1:0]         mul_cnt;

    logic [PRICE_W-1:0] unit_price;
    logic [QTY_W-1:0]   cur_qty;
    logic [QTY_W-1:0]   rd_lookup;
    logic [QTY_W:0]     add_sum;
    logic [TOTAL_W:0]   total_sum;
    logic [QTY_W-1:0]   new_qty;
    logic               reject;

    product_price_rom u_price_rom (
        .id    (id_r),
        .price (unit_price)
    );

    // Look up the latched line and the read-port line, then precompute the guard and new quantity
    always_comb begin
        cur_qty   = '0;
        rd_lookup = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (id_r == ID_W'(i)) begin
                cur_qty = qty_mem[i];
            end
            if (RD_ID == ID_W'(i)) begin
                rd_lookup = qty_mem[i];
            end
        end
        add_sum   = {1'b0, cur_qty} + {1'b0, qty_r};
        total_sum = {1'b0, TOTAL_PRICE} + (TOTAL_W + 1)'(product);
        new_qty   = (op_r == OP_ADD) ? add_sum[QTY_W-1:0] : (cur_qty - qty_r);
        reject    = (id_r >= ID_LIMIT)
                 || (qty_r == '0)
                 || ((op_r == OP_ADD) && add_sum[QTY_W])
                 || ((op_r == OP_REMOVE) && (qty_r > cur_qty));
    end

    // Command FSM with inline multiplier; all basket state and handshake outputs are registered here
    always_ff @(posedge CLOCK_50) begin
        if (RESET || CLEAR) begin
            state         <= IDLE;
            op_r          <= OP_ADD;
            id_r          <= '0;
            qty_r         <= '0;
            mcand         <= '0;
            mplier        <= '0;
            product       <= '0;
            mul_cnt       <= '0;
            LINE_NONEMPTY <= '0;
            ITEM_COUNT    <= '0;
            TOTAL_PRICE   <= '0;
            BUSY          <= 1'b0;
            ACK           <= 1'b0;
            ERR           <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                qty_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    ACK <= 1'b0;
                    ERR <= 1'b0;
                    if (CMD_EN) begin
                        op_r  <= CMD_OP;
                        id_r  <= PRODUCT_ID;
                        qty_r <= PRODUCT_QTY;
                        BUSY  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (reject) begin
                        ERR   <= 1'b1;
                        state <= ERRS;
                    end else begin
                        mcand   <= PROD_W'(unit_price);
                        mplier  <= qty_r;
                        product <= '0;
                        mul_cnt <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    mul_cnt <= mul_cnt + 2'd1;
                    if (mul_cnt == 2'd3) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    if ((op_r == OP_ADD) && total_sum[TOTAL_W]) begin
                        ERR   <= 1'b1;
                        state <= ERRS;
                    end else begin
                        for (int i = 0; i < NUM_PRODUCTS; i++) begin
                            if (id_r == ID_W'(i)) begin
                                qty_mem[i]       <= new_qty;
                                LINE_NONEMPTY[i] <= (new_qty != '0);
                            end
                        end
                        if (op_r == OP_ADD) begin
                            ITEM_COUNT  <= ITEM_COUNT + COUNT_W'(qty_r);
                            TOTAL_PRICE <= total_sum[TOTAL_W-1:0];
                        end else begin
                            ITEM_COUNT  <= ITEM_COUNT - COUNT_W'(qty_r);
                            TOTAL_PRICE <= TOTAL_PRICE - TOTAL_W'(product);
                        end
                        ACK   <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE, ERRS: begin
                    ACK   <= 1'b0;
                    ERR   <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read port follows qty[RD_ID] with one cycle of latency; cleared along with the basket
    always_ff @(posedge CLOCK_50) begin
        if (RESET || CLEAR) begin
            RD_QTY <= '0;
        end else begin
            RD_QTY <= rd_lookup;
        end
    end

endmodule
